plic_ctrl: RTL and testbench

- Platform-level interrupt arbiter that collects NUM_SRC level-sensitive external interrupt lines and produces the single meip input consumed by the machine CSR unit.
- Per-source gateway, priority, enable, a global threshold, and a claim/complete register pair, all accessed over the core's simple memory bus.
- Sits beside the timer block on the peripheral bus; software claims the winning source after trapping on interrupt_mach_extern.

---
 rtl/plic_ctrl_pkg.sv | 43 ++++
 rtl/plic_ctrl_if.sv | 21 ++
 rtl/plic_arbiter.sv | 31 +++
 rtl/plic_ctrl.sv | 129 ++++++++++++
 tb/tb_plic_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/plic_ctrl_pkg.sv
// Shared constants, register-file types and helpers for the platform interrupt controller.
package plic_ctrl_pkg;

  localparam int unsigned NUM_SRC = 8;
  localparam int unsigned PRIO_W  = 3;
  localparam int unsigned ID_W    = $clog2(NUM_SRC + 1);
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = 4;

  localparam logic [ADDR_W-1:0] plic_prio_base   = 10'h000;
  localparam logic [ADDR_W-1:0] plic_pend_addr   = 10'h080;
  localparam logic [ADDR_W-1:0] plic_enable_addr = 10'h100;
  localparam logic [ADDR_W-1:0] plic_thresh_addr = 10'h200;
  localparam logic [ADDR_W-1:0] plic_claim_addr  = 10'h204;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } bus_state_e;

  typedef logic [NUM_SRC:1][PRIO_W-1:0] prio_arr_t;

  typedef struct packed {
    prio_arr_t         prio;
    logic [NUM_SRC:1]  enable;
    logic [NUM_SRC:1]  pending;
    logic [NUM_SRC:1]  in_flight;
    logic [PRIO_W-1:0] threshold;
  } plic_reg_type;

  // Latched bus request; byte-offset bits are dropped since the map is word aligned.
  typedef struct packed {
    logic [ADDR_W-1:2] word;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } plic_req_t;

  function automatic plic_reg_type init_plic_reg();
    return '0;
  endfunction

endpackage

// File: rtl/plic_ctrl_if.sv
// Simple memory bus between the core and the interrupt controller.
interface plic_ctrl_if;

  logic                                mem_valid;
  logic [plic_ctrl_pkg::ADDR_W-1:0]    mem_addr;
  logic [plic_ctrl_pkg::DATA_W-1:0]    mem_wdata;
  logic [plic_ctrl_pkg::STRB_W-1:0]    mem_wstrb;
  logic                                mem_ready;
  logic [plic_ctrl_pkg::DATA_W-1:0]    mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/plic_arbiter.sv
// Combinational winner select: highest priority above threshold, ties to the lowest ID.
module plic_arbiter
  import plic_ctrl_pkg::*;
(
  input  logic [NUM_SRC:1]  pending_i,
  input  logic [NUM_SRC:1]  enable_i,
  input  prio_arr_t         prio_i,
  input  logic [PRIO_W-1:0] threshold_i,
  output logic [ID_W-1:0]   win_id_o,
  output logic [PRIO_W-1:0] win_prio_o
);

  logic [ID_W-1:0]   best_id;
  logic [PRIO_W-1:0] best_prio;

  // Scanning from the top ID down with >= leaves the lowest ID among equals.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int i = int'(NUM_SRC); i >= 1; i--) begin
      if (pending_i[i] && enable_i[i] && (prio_i[i] > threshold_i) && (prio_i[i] >= best_prio)) begin
        best_id   = ID_W'(i);
        best_prio = prio_i[i];
      end
    end
  end

  assign win_id_o   = best_id;
  assign win_prio_o = best_prio;

endmodule

// File: rtl/plic_ctrl.sv
// Platform interrupt controller: gateways, priority/enable/threshold registers,
// claim/complete and the registered meip line to the CSR unit.
module plic_ctrl
  import plic_ctrl_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  plic_ctrl_if.slave         bus,
  output logic               meip
);

  bus_state_e        state_q, state_d;
  plic_req_t         req_q, req_d;
  plic_reg_type      regs_q, regs_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              meip_q;

  logic [ID_W-1:0]   win_id;
  logic [PRIO_W-1:0] win_prio;
  logic [ID_W-1:0]   claim_id;
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] rd_mux_c;
  logic              unused_addr_bits;

  plic_arbiter u_arbiter (
    .pending_i   (regs_q.pending),
    .enable_i    (regs_q.enable),
    .prio_i      (regs_q.prio),
    .threshold_i (regs_q.threshold),
    .win_id_o    (win_id),
    .win_prio_o  (win_prio)
  );

  assign raddr            = {bus.mem_addr[ADDR_W-1:2], 2'b00};
  assign waddr            = {req_q.word, 2'b00};
  assign unused_addr_bits = ^bus.mem_addr[1:0];
  // The ID returned on a claim read is the one retired when the access completes.
  assign claim_id         = rdata_q[ID_W-1:0];

  always_comb begin
    rd_mux_c = '0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      if (raddr == plic_prio_base + ADDR_W'(4 * i)) rd_mux_c = DATA_W'(regs_q.prio[i]);
    end
    if (raddr == plic_pend_addr)   rd_mux_c = DATA_W'({regs_q.pending, 1'b0});
    if (raddr == plic_enable_addr) rd_mux_c = DATA_W'({regs_q.enable, 1'b0});
    if (raddr == plic_thresh_addr) rd_mux_c = DATA_W'(regs_q.threshold);
    if (raddr == plic_claim_addr)  rd_mux_c = DATA_W'(win_id);
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    regs_d  = regs_q;
    ready_d = 1'b0;
    rdata_d = '0;

    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      if (irq_src[i-1] && !regs_q.pending[i] && !regs_q.in_flight[i]) regs_d.pending[i] = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.mem_valid) begin
          state_d     = ST_RESP;
          req_d.word  = bus.mem_addr[ADDR_W-1:2];
          req_d.wdata = bus.mem_wdata;
          req_d.wstrb = bus.mem_wstrb;
          ready_d     = 1'b1;
          rdata_d     = (bus.mem_wstrb == '0) ? rd_mux_c : '0;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (req_q.wstrb == '0) begin
          if (waddr == plic_claim_addr) begin
            // Claim overrides a gateway set of the same source this cycle.
            for (int unsigned i = 1; i <= NUM_SRC; i++) begin
              if (claim_id == ID_W'(i)) begin
                regs_d.pending[i]   = 1'b0;
                regs_d.in_flight[i] = 1'b1;
              end
            end
          end
        end else begin
          if (req_q.wstrb[0]) begin
            for (int unsigned i = 1; i <= NUM_SRC; i++) begin
              if (waddr == plic_prio_base + ADDR_W'(4 * i)) regs_d.prio[i] = req_q.wdata[PRIO_W-1:0];
              if ((waddr == plic_claim_addr) && (req_q.wdata == DATA_W'(i))) regs_d.in_flight[i] = 1'b0;
            end
            if (waddr == plic_thresh_addr) regs_d.threshold = req_q.wdata[PRIO_W-1:0];
          end
          if (waddr == plic_enable_addr) begin
            for (int unsigned i = 1; i <= NUM_SRC; i++) begin
              if (req_q.wstrb[i/8]) regs_d.enable[i] = req_q.wdata[i];
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      regs_q  <= init_plic_reg();
      ready_q <= 1'b0;
      rdata_q <= '0;
      meip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      regs_q  <= regs_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      meip_q  <= (win_prio != '0);
    end
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign meip          = meip_q;

endmodule

// File: tb/tb_plic_ctrl.sv
// Directed bench for plic_ctrl: register table plus claim/complete/arbitration sequences.
module tb_plic_ctrl;

  logic       clock;
  logic       reset;
  logic [7:0] irq_src;
  logic       meip;

  plic_ctrl_if bus ();

  plic_ctrl dut (
    .clock   (clock),
    .reset   (reset),
    .irq_src (irq_src),
    .bus     (bus),
    .meip    (meip)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Starts and ends on a falling edge; covers latency and ready pulse width.
  task automatic xfer(input logic [9:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      output logic [31:0] rd);
    int lat;
    bit got;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = a;
    bus.mem_wdata = wd;
    bus.mem_wstrb = ws;
    lat = 0;
    got = 1'b0;
    rd  = '0;
    while (!got && lat < 8) begin
      @(negedge clock);
      lat++;
      if (bus.mem_ready) begin
        got = 1'b1;
        rd  = bus.mem_rdata;
      end
    end
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = '0;
    check("latency", 32'(lat), 32'd1);
    @(negedge clock);
    check("ready_pulse", 32'(bus.mem_ready), 32'd0);
    check("rdata_idle", bus.mem_rdata, 32'd0);
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    xfer(a, d, s, r);
  endtask

  task automatic rd_chk(input string nm, input logic [9:0] a, input logic [31:0] e);
    logic [31:0] r;
    xfer(a, 32'd0, 4'd0, r);
    check(nm, r, e);
  endtask

  task automatic wait_meip(input string nm, input logic e, input int max);
    int n = 0;
    while (meip !== e && n < max) begin
      @(negedge clock);
      n++;
    end
    check(nm, 32'(meip), 32'(e));
  endtask

  task automatic add(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] e, input string nm);
    vecs.push_back('{addr: a, wdata: d, wstrb: s, exp: e, name: nm});
  endtask

  initial begin
    reset         = 1'b0;
    irq_src       = 8'hFF;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;

    // Reset held with every source asserted
    repeat (2) @(negedge clock);
    check("rst_meip", 32'(meip), 32'd0);
    check("rst_ready", 32'(bus.mem_ready), 32'd0);
    check("rst_rdata", bus.mem_rdata, 32'd0);
    reset   = 1'b1;
    irq_src = 8'h00;
    @(negedge clock);
    rd_chk("rst_pending", 10'h080, 32'h0);
    rd_chk("rst_claim", 10'h204, 32'h0);
    check("rst_meip_after", 32'(meip), 32'd0);

    // Register map table
    add(10'h00C, 32'd2,        4'hF, 32'd0,     "");
    add(10'h00C, 32'd0,        4'h0, 32'd2,     "prio3");
    add(10'h100, 32'h08,       4'hF, 32'd0,     "");
    add(10'h100, 32'd0,        4'h0, 32'h08,    "enable");
    add(10'h200, 32'd0,        4'hF, 32'd0,     "");
    add(10'h200, 32'd0,        4'h0, 32'd0,     "thresh0");
    add(10'h000, 32'd7,        4'hF, 32'd0,     "");
    add(10'h000, 32'd0,        4'h0, 32'd0,     "prio0_ro");
    add(10'h3FC, 32'hFFFFFFFF, 4'hF, 32'd0,     "");
    add(10'h3FC, 32'd0,        4'h0, 32'd0,     "unmapped_3fc");
    add(10'h024, 32'd7,        4'hF, 32'd0,     "");
    add(10'h024, 32'd0,        4'h0, 32'd0,     "prio9_absent");
    add(10'h008, 32'd5,        4'h2, 32'd0,     "");
    add(10'h008, 32'd0,        4'h0, 32'd0,     "prio2_nostrb0");
    add(10'h008, 32'hFF,       4'h1, 32'd0,     "");
    add(10'h008, 32'd0,        4'h0, 32'd7,     "prio2_trunc");
    add(10'h00E, 32'd0,        4'h0, 32'd2,     "addr_lowbits");
    add(10'h100, 32'h1FF,      4'h1, 32'd0,     "");
    add(10'h100, 32'd0,        4'h0, 32'hFE,    "enable_byte0");
    add(10'h100, 32'h100,      4'h2, 32'd0,     "");
    add(10'h100, 32'd0,        4'h0, 32'h1FE,   "enable_byte1_set");
    add(10'h100, 32'h000,      4'h2, 32'd0,     "");
    add(10'h100, 32'd0,        4'h0, 32'hFE,    "enable_byte1_clr");
    add(10'h100, 32'h08,       4'hF, 32'd0,     "");
    add(10'h200, 32'hFFFFFFFF, 4'h1, 32'd0,     "");
    add(10'h200, 32'd0,        4'h0, 32'd7,     "thresh_trunc");
    add(10'h200, 32'd0,        4'hF, 32'd0,     "");
    add(10'h080, 32'hFF,       4'hF, 32'd0,     "");
    add(10'h080, 32'd0,        4'h0, 32'd0,     "pending_ro");
    add(10'h204, 32'd0,        4'h0, 32'd0,     "claim_none");
    for (int i = 0; i < vecs.size(); i++) begin
      logic [31:0] r;
      xfer(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, r);
      if (vecs[i].wstrb == 4'h0) check(vecs[i].name, r, vecs[i].exp);
    end

    // Basic flow on ID 3
    irq_src = 8'h04;
    @(negedge clock);
    check("basic_meip_t1", 32'(meip), 32'd0);
    @(negedge clock);
    check("basic_meip_t2", 32'(meip), 32'd1);
    rd_chk("basic_pending", 10'h080, 32'h08);
    rd_chk("basic_claim", 10'h204, 32'd3);
    wait_meip("basic_meip_fall", 1'b0, 2);
    rd_chk("basic_pending_inflight", 10'h080, 32'h0);
    irq_src = 8'h00;
    wr(10'h204, 32'd3, 4'hF);
    irq_src = 8'h04;
    wait_meip("basic_reraise", 1'b1, 3);
    rd_chk("basic_claim2", 10'h204, 32'd3);
    irq_src = 8'h00;
    wr(10'h204, 32'd3, 4'hF);

    // Tie goes to lowest ID, then priority raise reorders
    wr(10'h008, 32'd4, 4'hF);
    wr(10'h014, 32'd4, 4'hF);
    wr(10'h100, 32'h24, 4'hF);
    irq_src = 8'h12;
    wait_meip("arb_meip", 1'b1, 3);
    rd_chk("arb_tie_first", 10'h204, 32'd2);
    rd_chk("arb_tie_second", 10'h204, 32'd5);
    rd_chk("arb_empty", 10'h204, 32'd0);
    irq_src = 8'h00;
    wr(10'h204, 32'd2, 4'hF);
    wr(10'h204, 32'd5, 4'hF);
    irq_src = 8'h12;
    wr(10'h014, 32'd6, 4'hF);
    wait_meip("arb_meip2", 1'b1, 3);
    rd_chk("arb_prio_first", 10'h204, 32'd5);
    rd_chk("arb_prio_second", 10'h204, 32'd2);
    irq_src = 8'h00;
    wr(10'h204, 32'd5, 4'hF);
    wr(10'h204, 32'd2, 4'hF);

    // Threshold must be strictly exceeded
    wr(10'h100, 32'h02, 4'hF);
    wr(10'h004, 32'd3, 4'hF);
    wr(10'h200, 32'd3, 4'hF);
    irq_src = 8'h01;
    repeat (3) @(negedge clock);
    check("thr_equal_meip", 32'(meip), 32'd0);
    rd_chk("thr_pending", 10'h080, 32'h02);
    wr(10'h200, 32'd2, 4'hF);
    check("thr_meip_t1", 32'(meip), 32'd0);
    @(negedge clock);
    check("thr_meip_t2", 32'(meip), 32'd1);
    rd_chk("thr_claim", 10'h204, 32'd1);
    irq_src = 8'h00;
    wr(10'h204, 32'd1, 4'hF);
    wr(10'h200, 32'd0, 4'hF);

    // Held level source stays quiet while in flight
    wr(10'h100, 32'h10, 4'hF);
    wr(10'h010, 32'd1, 4'hF);
    irq_src = 8'h08;
    wait_meip("lvl_meip", 1'b1, 3);
    rd_chk("lvl_claim", 10'h204, 32'd4);
    repeat (3) @(negedge clock);
    rd_chk("lvl_pending_held", 10'h080, 32'h0);
    wr(10'h204, 32'd7, 4'hF);
    wr(10'h204, 32'd0, 4'hF);
    wr(10'h204, 32'd9, 4'hF);
    wr(10'h204, 32'd4, 4'h2);
    rd_chk("lvl_bad_complete", 10'h080, 32'h0);
    check("lvl_meip_quiet", 32'(meip), 32'd0);
    wr(10'h204, 32'd4, 4'hF);
    @(negedge clock);
    check("lvl_meip_t1", 32'(meip), 32'd0);
    @(negedge clock);
    check("lvl_meip_t2", 32'(meip), 32'd1);
    rd_chk("lvl_pending_reset", 10'h080, 32'h10);

    // Reset during a pending request
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 10'h100;
    bus.mem_wstrb = 4'h0;
    reset         = 1'b0;
    @(negedge clock);
    check("midrst_ready", 32'(bus.mem_ready), 32'd0);
    check("midrst_meip", 32'(meip), 32'd0);
    bus.mem_valid = 1'b0;
    irq_src       = 8'h00;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    rd_chk("midrst_enable", 10'h100, 32'h0);
    rd_chk("midrst_prio4", 10'h010, 32'h0);
    rd_chk("midrst_pending", 10'h080, 32'h0);
    rd_chk("midrst_claim", 10'h204, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
